// File: rtl/addsub_pkg.sv
// Shared types and constant helpers for the pipelined adder/subtractor.
package addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } addsub_op_e;

    // Widest datapath the limit helpers can describe; callers truncate to WIDTH.
    localparam int unsigned LIMIT_W = 64;

    function automatic logic [LIMIT_W-1:0] signed_min(input int unsigned w);
        return LIMIT_W'(1) << (w - 1);
    endfunction

    function automatic logic [LIMIT_W-1:0] signed_max(input int unsigned w);
        return signed_min(w) - LIMIT_W'(1);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One CW-bit ripple-carry slice built from full-adder cells; also exposes the
// carry into its top bit so the most significant slice can report overflow.
module addsub_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          c_msb
);

    logic [CW:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CW; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[CW];
    assign c_msb = c[CW-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract with a registered carry between STAGES ripple chunks
// and a global valid/ready stall. Define ADDSUB_SAT_EN to clamp on signed overflow.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int CW = WIDTH / STAGES;

    addsub_op_e       op;
    logic [WIDTH-1:0] b_cond;
    logic             c0;
    logic             adv;

    // Per-stage pipeline registers: skewed operands, partial sum, chunk carry.
    logic             v_r [STAGES];
    logic [WIDTH-1:0] a_r [STAGES];
    logic [WIDTH-1:0] b_r [STAGES];
    logic [WIDTH-1:0] s_r [STAGES];
    logic             c_r [STAGES];

    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;
    logic             zero_q;

    assign op     = addsub_op_e'(i_op);
    assign b_cond = (op == OP_SUB) ? ~i_b : i_b;
    assign c0     = (op == OP_SUB) ? ~i_cin : i_cin;

    assign o_valid = v_r[STAGES-1];
    assign adv     = ~o_valid | i_ready;
    assign o_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_cur;
        logic [WIDTH-1:0] b_cur;
        logic [WIDTH-1:0] s_cur;
        logic [WIDTH-1:0] s_nxt;
        logic             c_cur;
        logic             v_cur;
        logic [CW-1:0]    ch_sum;
        logic             ch_cout;
        logic             ch_cmsb;

        if (k == 0) begin : g_first
            assign a_cur = i_a;
            assign b_cur = b_cond;
            assign s_cur = '0;
            assign c_cur = c0;
            assign v_cur = i_valid;
        end else begin : g_next
            assign a_cur = a_r[k-1];
            assign b_cur = b_r[k-1];
            assign s_cur = s_r[k-1];
            assign c_cur = c_r[k-1];
            assign v_cur = v_r[k-1];
        end

        addsub_chunk #(.CW(CW)) u_chunk (
            .a     (a_cur[k*CW +: CW]),
            .b     (b_cur[k*CW +: CW]),
            .cin   (c_cur),
            .sum   (ch_sum),
            .cout  (ch_cout),
            .c_msb (ch_cmsb)
        );

        // Only chunks below k are ever nonzero in s_cur, so OR-ing in chunk k is exact.
        assign s_nxt = s_cur | (WIDTH'(ch_sum) << (k * CW));

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                v_r[k] <= 1'b0;
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
                c_r[k] <= 1'b0;
            end else if (adv) begin
                v_r[k] <= v_cur;
                a_r[k] <= a_cur;
                b_r[k] <= b_cur;
                s_r[k] <= s_nxt;
                c_r[k] <= ch_cout;
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic             ovf;
            logic [WIDTH-1:0] s_fin;

            assign ovf = ch_cout ^ ch_cmsb;
`ifdef ADDSUB_SAT_EN
            assign s_fin = !ovf            ? s_nxt :
                           a_cur[WIDTH-1]  ? WIDTH'(signed_min(WIDTH)) :
                                             WIDTH'(signed_max(WIDTH));
`else
            assign s_fin = s_nxt;
`endif

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    sum_q   <= '0;
                    carry_q <= 1'b0;
                    ovf_q   <= 1'b0;
                    zero_q  <= 1'b0;
                end else if (adv) begin
                    sum_q   <= s_fin;
                    carry_q <= ch_cout;
                    ovf_q   <= ovf;
                    zero_q  <= (s_fin == '0);
                end
            end
        end
    end

    assign o_sum   = sum_q;
    assign o_carry = carry_q;
    assign o_ovf   = ovf_q;
    assign o_zero  = zero_q;

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake. It succeeds the fixed 8-bit combinational ripple adder. The WIDTH-bit add is split into STAGES equal ripple chunks, with a registered carry between chunks, so wide datapaths close timing. It sits between operand-producing logic and ALU/accumulator consumers, and stalls under downstream backpressure.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGES and ≥ 2
STAGES, 4, pipeline stages (chunks); 1 ≤ STAGES ≤ WIDTH; chunk width CW = WIDTH/STAGES

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  upstream operands valid
o_ready  output  1  block accepts operands this cycle
i_op  input  1  0 = add (A+B+cin), 1 = subtract (A−B−cin)
i_a  input  WIDTH  operand A
i_b  input  WIDTH  operand B
i_cin  input  1  carry-in (add) / borrow-in (subtract)
o_valid  output  1  result valid
i_ready  input  1  downstream accepts result
o_sum  output  WIDTH  result
o_carry  output  1  carry out of MSB (for subtract: 1 = no borrow)
o_ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB
o_zero  output  1  o_sum == 0

Behaviour:
- Reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n. While i_rst_n=0, all stage valid flags, data, carry and skew registers clear to 0. Outputs: o_valid=0, o_sum=0, o_carry=0, o_ovf=0, o_zero=0. o_ready=1 after reset.
- Reset mid-operation: all in-flight results are discarded. No output pulse occurs on reset release.
- Operand conditioning, done combinationally at input:
  - B' = i_op ? ~i_b : i_b
  - c0 = i_op ? ~i_cin : i_cin
  - Subtract is therefore A + ~B + ~borrow.
- Stage k (0..STAGES−1):
  - Adds chunk k of A and B', bits [k*CW +: CW], plus the carry registered from stage k−1 (stage 0 uses c0).
  - Upper chunks of A/B' are carried forward in skew registers.
  - Completed lower-chunk sums are carried forward in deskew registers, so all chunks of one transaction exit together.
- Last stage:
  - Registers o_carry, plus the carry into the MSB for o_ovf.
  - o_zero is computed from the assembled sum and registered with it.
- Latency: exactly STAGES cycles from an accepted input (i_valid & o_ready) to o_valid, when there is no stall. STAGES=1 gives a single registered stage.
- Throughput: one transaction per cycle.
- Handshake/stall:
  - adv = ~o_valid | i_ready; o_ready = adv.
  - All stage registers update only when adv=1 (global stall); they hold when adv=0.
  - Valid bubbles propagate as per-stage valid flags.
  - Data registers may load when the valid flag is 0, but outputs are only meaningful when o_valid=1.
- o_valid/o_sum/flags stay stable while o_valid=1 and i_ready=0.
- Simultaneous output pop and input push on a full pipeline: both proceed in the same cycle, with no bubble.
- i_op and i_cin are sampled per transaction. Mixed add/sub back-to-back is legal.
- Wrap-around: results are modulo 2^WIDTH. Carry and overflow are reported but never trapped.

Optional Feature:
ADDSUB_SAT_EN
- Defined: when o_ovf would be 1, o_sum is clamped to the signed limit instead of wrapping.
  - Clamp to 0x7FF..F if operand A's sign bit is 0.
  - Clamp to 0x800..0 if operand A's sign bit is 1.
  - o_ovf is still reported as 1. o_carry is unchanged.
  - o_zero reflects the clamped value.
  - Saturation adds no latency; it is applied in the last stage.
- Undefined: pure modular result, and there is no saturation logic.

Decomposition:
- Package addsub_pkg:
  - typedef enum logic {OP_ADD=1'b0, OP_SUB=1'b1} addsub_op_e
  - functions for signed max/min constant generation
- One natural sub-module: addsub_chunk.
  - A CW-bit ripple of full_adder cells, with carry in/out.
  - It also exposes carry-into-MSB for use by the last chunk.
  - It is instantiated STAGES times in a generate loop.

Test Plan:
1. WIDTH=16, STAGES=4, add 0x00FF + 0x0001, cin=0 → after 4 cycles o_sum=0x0100, carry=0, ovf=0, zero=0 (carry crosses chunk boundaries).
2. Add 0x7FFF + 0x0001 → o_sum=0x8000, ovf=1, carry=0. With ADDSUB_SAT_EN: o_sum=0x7FFF, ovf=1.
3. Sub 0x0005 − 0x0005, cin=0 → o_sum=0x0000, zero=1, carry=1. Sub 0x0000 − 0x0001 → o_sum=0xFFFF, carry=0.
4. Stream 8 back-to-back mixed add/sub transactions, i_ready=1 → 8 consecutive o_valid results in order, first at cycle 4, matching the reference model.
5. Stream with i_ready held low for 5 cycles mid-burst → o_ready drops while o_valid=1. Outputs hold stable. No loss or duplication; order preserved.
6. Assert i_rst_n=0 for 1 cycle with 3 transactions in flight → o_valid=0 immediately and all outputs 0. No stale result after release. Next accepted transaction appears after exactly 4 cycles.
